// File: rtl/id_ex_if.sv
// Decode/execute bundle for the ID/EX pipeline register.
// The master side is decode plus execute; the slave side is id_ex_reg.
interface id_ex_if;
  logic [31:0] ins_i;
  logic [31:0] ins_addr_i;
  logic        id_valid_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        jump_en_i;
  logic        hold_flag_i;
  logic [4:0]  ex_rd_addr_i;
  logic [31:0] ex_rd_data_i;
  logic        ex_rd_wr_en_i;
  logic [31:0] ins_o;
  logic [31:0] ins_addr_o;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic        valid_o;
  logic        stall_o;
  logic [15:0] bubble_cnt_o;

  modport master (
    output ins_i, ins_addr_i, id_valid_i, rs1_addr_i, rs2_addr_i,
           rs1_data_i, rs2_data_i, jump_en_i, hold_flag_i,
           ex_rd_addr_i, ex_rd_data_i, ex_rd_wr_en_i,
    input  ins_o, ins_addr_o, rs1_data_o, rs2_data_o, valid_o,
           stall_o, bubble_cnt_o
  );

  modport slave (
    input  ins_i, ins_addr_i, id_valid_i, rs1_addr_i, rs2_addr_i,
           rs1_data_i, rs2_data_i, jump_en_i, hold_flag_i,
           ex_rd_addr_i, ex_rd_data_i, ex_rd_wr_en_i,
    output ins_o, ins_addr_o, rs1_data_o, rs2_data_o, valid_o,
           stall_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: bubbles on jump flush and load-use, freezes on hold.
// Optional macro ID_EX_FORWARD_EN forwards execute write-back data into the operands.
module id_ex_reg #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] NOP_INS      = 32'h0000_0013
) (
  input logic    clk,
  input logic    rst_n,
  id_ex_if.slave bus
);

  localparam int unsigned CNT_W = 3;
  localparam logic [6:0]  OPC_LOAD = 7'b0000011;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_LU    = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   flush_cnt;
  logic [31:0]        ins_q;
  logic [31:0]        ins_addr_q;
  logic [31:0]        rs1_data_q;
  logic [31:0]        rs2_data_q;
  logic               valid_q;
  logic [15:0]        bubble_cnt_q;

  logic               lu;
  logic               do_bubble;
  logic               do_load;
  logic [31:0]        rs1_sel;
  logic [31:0]        rs2_sel;

  // Load in execute whose destination is read by the instruction now in decode.
  always_comb begin
    lu = (ins_q[6:0] == OPC_LOAD) && (ins_q[11:7] != 5'd0) && bus.id_valid_i &&
         ((ins_q[11:7] == bus.rs1_addr_i) || (ins_q[11:7] == bus.rs2_addr_i));
  end

  assign bus.stall_o = !bus.jump_en_i &
                       (bus.hold_flag_i | ((state == S_RUN) & lu));

  // Per-edge action selection, jump over hold over flush over load-use.
  always_comb begin
    do_bubble = 1'b0;
    do_load   = 1'b0;
    if (bus.jump_en_i) begin
      do_bubble = 1'b1;
    end else if (!bus.hold_flag_i) begin
      case (state)
        S_FLUSH: do_bubble = 1'b1;
        S_LU:    do_load   = 1'b1;
        S_RUN:   begin
          do_bubble = lu;
          do_load   = !lu;
        end
        default: do_load = 1'b0;
      endcase
    end
  end

`ifdef ID_EX_FORWARD_EN
  always_comb begin
    rs1_sel = bus.rs1_data_i;
    rs2_sel = bus.rs2_data_i;
    if (bus.ex_rd_wr_en_i && (bus.ex_rd_addr_i != 5'd0) &&
        (bus.ex_rd_addr_i == bus.rs1_addr_i))
      rs1_sel = bus.ex_rd_data_i;
    if (bus.ex_rd_wr_en_i && (bus.ex_rd_addr_i != 5'd0) &&
        (bus.ex_rd_addr_i == bus.rs2_addr_i))
      rs2_sel = bus.ex_rd_data_i;
  end
`else
  always_comb begin
    rs1_sel = bus.rs1_data_i;
    rs2_sel = bus.rs2_data_i;
  end
  wire unused_ex_rd = ^{1'b0, bus.ex_rd_addr_i, bus.ex_rd_data_i, bus.ex_rd_wr_en_i};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_RUN;
      flush_cnt    <= '0;
      ins_q        <= NOP_INS;
      ins_addr_q   <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      valid_q      <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      if (do_bubble) begin
        ins_q      <= NOP_INS;
        ins_addr_q <= '0;
        rs1_data_q <= '0;
        rs2_data_q <= '0;
        valid_q    <= 1'b0;
        if (bubble_cnt_q != 16'hFFFF)
          bubble_cnt_q <= bubble_cnt_q + 16'd1;
      end else if (do_load) begin
        ins_q      <= bus.id_valid_i ? bus.ins_i : NOP_INS;
        ins_addr_q <= bus.ins_addr_i;
        rs1_data_q <= rs1_sel;
        rs2_data_q <= rs2_sel;
        valid_q    <= bus.id_valid_i;
      end

      // State/flush counter; a jump (re)starts the flush window.
      if (bus.jump_en_i) begin
        flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
        state     <= (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
      end else if (!bus.hold_flag_i) begin
        case (state)
          S_FLUSH: begin
            flush_cnt <= flush_cnt - CNT_W'(1);
            if (flush_cnt <= CNT_W'(1)) state <= S_RUN;
          end
          S_LU:    state <= S_RUN;
          S_RUN:   if (lu) state <= S_LU;
          default: state <= S_RUN;
        endcase
      end
    end
  end

  assign bus.ins_o        = ins_q;
  assign bus.ins_addr_o   = ins_addr_q;
  assign bus.rs1_data_o   = rs1_data_q;
  assign bus.rs2_data_o   = rs2_data_q;
  assign bus.valid_o      = valid_q;
  assign bus.bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed testbench for id_ex_reg with FLUSH_CYCLES=2.
module tb_id_ex_reg;

  logic clk = 1'b0;
  logic rst_n;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  id_ex_if bus ();

  id_ex_reg #(.FLUSH_CYCLES(2), .NOP_INS(32'h0000_0013)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] LW   = 32'h0001_2283;
  localparam logic [31:0] ADD  = 32'h0012_8333;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.ins_i      = ins;
    bus.ins_addr_i = pc;
    bus.rs1_addr_i = r1;
    bus.rs2_addr_i = r2;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.id_valid_i    = 1'b1;
    bus.rs1_data_i    = 32'h11;
    bus.rs2_data_i    = 32'h22;
    bus.jump_en_i     = 1'b0;
    bus.hold_flag_i   = 1'b0;
    bus.ex_rd_addr_i  = 5'd0;
    bus.ex_rd_data_i  = 32'h0;
    bus.ex_rd_wr_en_i = 1'b0;
    drive(32'h0050_0093, 32'h100, 5'd0, 5'd5);

    // Reset holds outputs regardless of inputs
    tick(); tick();
    check("rst_ins",   bus.ins_o, NOP);
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_cnt",   32'(bus.bubble_cnt_o), 32'd0);
    check("rst_addr",  bus.ins_addr_o, 32'h0);
    rst_n = 1'b1;

    tick();
    check("load_ins",   bus.ins_o, 32'h0050_0093);
    check("load_addr",  bus.ins_addr_o, 32'h100);
    check("load_valid", 32'(bus.valid_o), 32'd1);
    check("load_rs1",   bus.rs1_data_o, 32'h11);

    // Single jump: two bubbles then resume
    drive(32'h00a0_0113, 32'h104, 5'd0, 5'd10);
    bus.jump_en_i = 1'b1;
    #1 check("jump_stall", 32'(bus.stall_o), 32'd0);
    tick();
    bus.jump_en_i = 1'b0;
    check("fl1_ins",   bus.ins_o, NOP);
    check("fl1_valid", 32'(bus.valid_o), 32'd0);
    check("fl1_addr",  bus.ins_addr_o, 32'h0);
    check("fl1_cnt",   32'(bus.bubble_cnt_o), 32'd1);
    tick();
    check("fl2_ins", bus.ins_o, NOP);
    check("fl2_cnt", 32'(bus.bubble_cnt_o), 32'd2);
    tick();
    check("fl_res_ins",   bus.ins_o, 32'h00a0_0113);
    check("fl_res_valid", 32'(bus.valid_o), 32'd1);
    check("fl_res_cnt",   32'(bus.bubble_cnt_o), 32'd2);

    // Jump during flush restarts the count
    bus.jump_en_i = 1'b1;
    tick();
    tick();
    bus.jump_en_i = 1'b0;
    check("rj_cnt", 32'(bus.bubble_cnt_o), 32'd4);
    tick();
    check("rj_ins3", bus.ins_o, NOP);
    check("rj_cnt3", 32'(bus.bubble_cnt_o), 32'd5);
    tick();
    check("rj_res",  bus.ins_o, 32'h00a0_0113);
    check("rj_cnt4", 32'(bus.bubble_cnt_o), 32'd5);

    // Load-use: lw x5 followed by add x6,x5,x1
    drive(LW, 32'h108, 5'd2, 5'd0);
    tick();
    check("lw_ins", bus.ins_o, LW);
    drive(ADD, 32'h10c, 5'd5, 5'd1);
    #1 check("lu_stall", 32'(bus.stall_o), 32'd1);
    tick();
    check("lu_ins",    bus.ins_o, NOP);
    check("lu_valid",  32'(bus.valid_o), 32'd0);
    check("lu_cnt",    32'(bus.bubble_cnt_o), 32'd6);
    check("lu_stall2", 32'(bus.stall_o), 32'd0);
    tick();
    check("lu_add",  bus.ins_o, ADD);
    check("lu_addr", bus.ins_addr_o, 32'h10c);
    check("lu_cnt2", 32'(bus.bubble_cnt_o), 32'd6);

    // Jump together with load-use: jump wins, flush follows instead of S_LU
    drive(LW, 32'h110, 5'd2, 5'd0);
    tick();
    drive(ADD, 32'h114, 5'd5, 5'd1);
    bus.jump_en_i = 1'b1;
    #1 check("jlu_stall", 32'(bus.stall_o), 32'd0);
    tick();
    bus.jump_en_i = 1'b0;
    check("jlu_ins1", bus.ins_o, NOP);
    check("jlu_cnt1", 32'(bus.bubble_cnt_o), 32'd7);
    tick();
    check("jlu_ins2", bus.ins_o, NOP);
    check("jlu_cnt2", 32'(bus.bubble_cnt_o), 32'd8);
    tick();
    check("jlu_res", bus.ins_o, ADD);
    check("jlu_pc",  bus.ins_addr_o, 32'h114);

    // Hold for three cycles while inputs change
    bus.hold_flag_i = 1'b1;
    drive(32'h0030_0193, 32'h118, 5'd0, 5'd3);
    #1 check("hold_stall", 32'(bus.stall_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(32'h0030_0193 + 32'(i), 32'h11c + 32'(4 * i), 5'd0, 5'd3);
    end
    check("hold_ins",  bus.ins_o, ADD);
    check("hold_addr", bus.ins_addr_o, 32'h114);
    check("hold_cnt",  32'(bus.bubble_cnt_o), 32'd8);
    bus.jump_en_i = 1'b1;
    #1 check("hj_stall", 32'(bus.stall_o), 32'd0);
    tick();
    bus.jump_en_i   = 1'b0;
    bus.hold_flag_i = 1'b0;
    check("hj_ins", bus.ins_o, NOP);
    check("hj_cnt", 32'(bus.bubble_cnt_o), 32'd9);
    tick();
    check("hj_cnt2", 32'(bus.bubble_cnt_o), 32'd10);

    // Invalid decode slot: NOP captured, not counted
    bus.id_valid_i = 1'b0;
    drive(32'h0040_0213, 32'h130, 5'd0, 5'd4);
    tick();
    check("inv_ins",   bus.ins_o, NOP);
    check("inv_valid", 32'(bus.valid_o), 32'd0);
    check("inv_cnt",   32'(bus.bubble_cnt_o), 32'd10);

    // Execute write-back operand selection
    bus.id_valid_i    = 1'b1;
    drive(32'h0002_8393, 32'h134, 5'd5, 5'd0);
    bus.rs1_data_i    = 32'h0;
    bus.ex_rd_addr_i  = 5'd5;
    bus.ex_rd_data_i  = 32'hDEAD_BEEF;
    bus.ex_rd_wr_en_i = 1'b1;
    tick();
`ifdef ID_EX_FORWARD_EN
    check("fwd_rs1", bus.rs1_data_o, 32'hDEAD_BEEF);
`else
    check("fwd_rs1", bus.rs1_data_o, 32'h0);
`endif
    bus.ex_rd_addr_i = 5'd0;
    bus.rs1_data_i   = 32'h55;
    tick();
    check("fwd_x0", bus.rs1_data_o, 32'h55);
    bus.ex_rd_wr_en_i = 1'b0;

    // Async reset in the middle of a hold
    bus.hold_flag_i = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check("mr_ins",   bus.ins_o, NOP);
    check("mr_cnt",   32'(bus.bubble_cnt_o), 32'd0);
    check("mr_valid", 32'(bus.valid_o), 32'd0);
    bus.hold_flag_i = 1'b0;
    tick();
    rst_n = 1'b1;

    // Saturation under a held jump
    bus.jump_en_i = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    check("sat_cnt", 32'(bus.bubble_cnt_o), 32'h0000_FFFF);
    check("sat_ins", bus.ins_o, NOP);
    bus.jump_en_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between the decode stage and the execute stage of the RV32I core.
- Captures the decoded instruction, its PC and its operand data each cycle, and presents them to execute.
- Inserts NOP bubbles on taken jumps (flush) and on load-use hazards, and freezes on execute hold.
- Produces the upstream stall signal for the fetch and decode stages.

Parameters:
- FLUSH_CYCLES, 2, number of consecutive bubbles issued after a taken jump/branch (range 1-7).
- NOP_INS, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ins_i  in  32  instruction from decode.
- ins_addr_i  in  32  PC of ins_i.
- id_valid_i  in  1  ins_i is a real instruction.
- rs1_addr_i  in  5  rs1 index of ins_i.
- rs2_addr_i  in  5  rs2 index of ins_i.
- rs1_data_i  in  32  register-file read data, rs1.
- rs2_data_i  in  32  register-file read data, rs2.
- jump_en_i  in  1  taken jump/branch from execute.
- hold_flag_i  in  1  execute requests freeze.
- ex_rd_addr_i  in  5  execute write-back index.
- ex_rd_data_i  in  32  execute write-back data.
- ex_rd_wr_en_i  in  1  execute write-back enable.
- ins_o  out  32  instruction to execute.
- ins_addr_o  out  32  PC to execute.
- rs1_data_o  out  32  operand 1 to execute.
- rs2_data_o  out  32  operand 2 to execute.
- valid_o  out  1  ins_o is a real instruction.
- stall_o  out  1  fetch/decode must hold (combinational).
- bubble_cnt_o  out  16  saturating count of inserted bubbles.

Behaviour:
- Reset (async, rst_n=0):
  - ins_o=NOP_INS; ins_addr_o, rs1_data_o, rs2_data_o = 0.
  - valid_o=0, bubble_cnt_o=0, flush_cnt=0, state=S_RUN.
- Latency: one cycle; an accepted input appears on the outputs after the next rising edge.
- Load-use hazard (lu):
  - Asserted when ins_o[6:0]==7'b0000011, ins_o[11:7]!=0, id_valid_i=1, and ins_o[11:7] equals rs1_addr_i or rs2_addr_i.
  - Both indices are compared regardless of format (conservative).
- stall_o = !jump_en_i & (hold_flag_i | (state==S_RUN & lu)).
- Per-edge action, highest priority first:
  1. jump_en_i=1: load a bubble; flush_cnt<=FLUSH_CYCLES-1; state<=S_FLUSH if FLUSH_CYCLES>1, else S_RUN. A jump during S_FLUSH restarts the count.
  2. hold_flag_i=1: all registers and state unchanged; no bubble counted.
  3. state==S_FLUSH: load a bubble; flush_cnt decrements; state<=S_RUN when flush_cnt reaches 0 after the decrement.
  4. state==S_RUN and lu: load a bubble; state<=S_LU. Decode holds because stall_o=1.
  5. state==S_LU: load inputs normally; state<=S_RUN. lu is not re-evaluated in S_LU because ins_o is now a NOP.
  6. Otherwise: ins_o<=ins_i, ins_addr_o<=ins_addr_i, rs1/rs2_data_o<=selected operand data, valid_o<=id_valid_i.
- A bubble sets ins_o=NOP_INS, valid_o=0, and ins_addr_o, rs1_data_o, rs2_data_o = 0. Every bubble increments bubble_cnt_o, saturating at 16'hFFFF.
- Invalid input (id_valid_i=0) in a normal load is captured as NOP_INS with valid_o=0 and is not counted.
- jump_en_i and lu in the same cycle: the jump wins and no S_LU entry occurs.
- Reset asserted mid-flush or mid-hold: immediate return to the reset values.
- FSM states: S_RUN, S_FLUSH, S_LU, encoded in 2 bits. Unused encodings go to S_RUN.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: on a normal load, if ex_rd_wr_en_i=1, ex_rd_addr_i!=0 and ex_rd_addr_i==rs1_addr_i, capture ex_rd_data_i into rs1_data_o instead of rs1_data_i. rs2 is handled identically and independently.
- Undefined: the ex_rd_* inputs are ignored and register-file data is always captured. The decode stage must then resolve same-cycle write/read hazards itself.

Test Plan:
- Reset: hold rst_n=0 while driving inputs → ins_o=32'h13, valid_o=0, bubble_cnt_o=0. Release and drive ins_i=32'h00500093 (addi x1,x0,5), PC=0x100 → next cycle ins_o=32'h00500093, ins_addr_o=0x100, valid_o=1.
- Flush: pulse jump_en_i for one cycle with FLUSH_CYCLES=2 → two consecutive NOP cycles with valid_o=0, then normal flow resumes; bubble_cnt_o=2. A second jump during the flush → count restarts, 2 more bubbles.
- Load-use: ins_o=lw x5,0(x2) (32'h00012283); incoming add x6,x5,x1 → stall_o=1 for one cycle, one NOP issued, then the add is captured; bubble_cnt_o +1.
- Hold: hold_flag_i=1 for 3 cycles while inputs change → outputs frozen, stall_o=1, bubble_cnt_o unchanged. Jump asserted during the hold → bubble loaded, stall_o=0.
- Forward (ID_EX_FORWARD_EN defined): ex_rd_addr_i=5, ex_rd_data_i=0xDEADBEEF, ex_rd_wr_en_i=1, rs1_addr_i=5, rs1_data_i=0 → rs1_data_o=0xDEADBEEF. With ex_rd_addr_i=0 → rs1_data_o=rs1_data_i.
- Saturation: force 70000 bubbles via a held jump → bubble_cnt_o=16'hFFFF, no wrap.
